// File: rtl/mem_array_mp.sv
// Multi-read-port memory: one byte-enabled write port, RPORTS registered read ports, optional clear-after-reset.
// Define MEM_ARRAY_MP_FWD_EN to forward same-edge write data to read ports.
module mem_array_mp #(
  parameter int DBITS        = 32,
  parameter int ABITS        = 5,
  parameter int WORDS        = 1 << ABITS,
  parameter int RPORTS       = 2,
  parameter     MFILE        = "",
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [RPORTS*ABITS-1:0]   RADDR,
  output logic [RPORTS*DBITS-1:0]   DOUT,
  input  logic [ABITS-1:0]          WADDR,
  input  logic [DBITS-1:0]          DIN,
  input  logic                      WE,
  input  logic [DBITS/8-1:0]        BE,
  output logic                      BUSY
);

  localparam int NB = DBITS / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                    state_q, state_d;
  logic [ABITS-1:0]          cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic [RPORTS*DBITS-1:0]   dout_q, dout_d;
  logic [RPORTS*DBITS-1:0]   rd_flat;
  logic                      clr_we;
  logic                      wr_en;

  function automatic logic in_range(input logic [ABITS-1:0] addr);
    return int'(addr) < WORDS;
  endfunction

  assign clr_we = !RESET && (state_q == CLEAR);
  assign wr_en  = !RESET && (state_q == READY) && WE && in_range(WADDR);

  // One replica per read port so each maps onto its own block RAM.
  for (genvar g = 0; g < RPORTS; g++) begin : g_rep
    logic [DBITS-1:0]  mem [WORDS];
    logic [ABITS-1:0]  ra;

    assign ra = RADDR[g*ABITS +: ABITS];

    always_ff @(posedge CLK) begin
      if (clr_we) begin
        mem[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < NB; k++) begin
          if (BE[k]) mem[WADDR][8*k +: 8] <= DIN[8*k +: 8];
        end
      end
    end

    assign rd_flat[g*DBITS +: DBITS] = in_range(ra) ? mem[ra] : '0;
  end

  always_comb begin
    logic [DBITS-1:0] word;
    logic [ABITS-1:0] ra;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dout_d  = '0;
    word    = '0;
    ra      = '0;
    case (state_q)
      CLEAR: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ABITS'(WORDS - 1)) begin
          state_d = READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        busy_d = 1'b0;
        for (int p = 0; p < RPORTS; p++) begin
          ra   = RADDR[p*ABITS +: ABITS];
          word = rd_flat[p*DBITS +: DBITS];
`ifdef MEM_ARRAY_MP_FWD_EN
          if (wr_en && (WADDR == ra)) begin
            for (int k = 0; k < NB; k++) begin
              if (BE[k]) word[8*k +: 8] = DIN[8*k +: 8];
            end
          end
`endif
          dout_d[p*DBITS +: DBITS] = word;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= CLR_ON_RESET ? CLEAR : READY;
      cnt_q   <= '0;
      busy_q  <= CLR_ON_RESET;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign DOUT = dout_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_mem_array_mp.sv
// Randomised self-checking bench for mem_array_mp against a word-array reference model.
module tb_mem_array_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] raddr;
  logic [95:0] dout;
  logic [4:0]  waddr;
  logic [31:0] din;
  logic        we;
  logic [3:0]  be;
  logic        busy;

  logic        rst2;
  logic [4:0]  raddr2;
  logic [31:0] dout2;
  logic [4:0]  waddr2;
  logic [31:0] din2;
  logic        we2;
  logic [3:0]  be2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];

  always #5 clk = ~clk;

  mem_array_mp #(.DBITS(32), .ABITS(5), .WORDS(32), .RPORTS(3), .CLR_ON_RESET(1'b1)) u_dut (
    .CLK(clk), .RESET(rst), .RADDR(raddr), .DOUT(dout), .WADDR(waddr),
    .DIN(din), .WE(we), .BE(be), .BUSY(busy)
  );

  mem_array_mp #(.DBITS(32), .ABITS(5), .WORDS(24), .RPORTS(1), .CLR_ON_RESET(1'b0)) u_dut_nc (
    .CLK(clk), .RESET(rst2), .RADDR(raddr2), .DOUT(dout2), .WADDR(waddr2),
    .DIN(din2), .WE(we2), .BE(be2), .BUSY(busy2)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one READY-state cycle, predict DOUT from the model, update the model, check.
  task automatic cycle(input string tag, input logic w, input logic [4:0] wa, input logic [31:0] d,
                       input logic [3:0] b, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    logic [95:0] exp;
    logic [4:0]  ra [3];
    logic [31:0] v;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    we = w; waddr = wa; din = d; be = b; raddr = {r2, r1, r0};
    for (int p = 0; p < 3; p++) begin
      v = mdl[ra[p]];
`ifdef MEM_ARRAY_MP_FWD_EN
      if (w && wa == ra[p])
        for (int k = 0; k < 4; k++) if (b[k]) v[8*k +: 8] = d[8*k +: 8];
`endif
      exp[p*32 +: 32] = v;
    end
    if (w) for (int k = 0; k < 4; k++) if (b[k]) mdl[wa][8*k +: 8] = d[8*k +: 8];
    tick();
    we = 1'b0;
    chk(tag, dout, exp);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      if (n == 0 || n == 31) chk({tag, "_dout0"}, dout, 96'h0);
      we = 1'b1; waddr = 5'd3; din = 32'hFFFF_FFFF; be = 4'hF; raddr = {5'd3, 5'd3, 5'd3};
      n++;
      tick();
    end
    we = 1'b0;
    chk(tag, 96'(n), 96'd32);
  endtask

  initial begin
    logic [31:0] a_val, b_val;
    rst = 1'b1; raddr = '0; waddr = '0; din = '0; we = 1'b0; be = '0;
    rst2 = 1'b1; raddr2 = '0; waddr2 = '0; din2 = '0; we2 = 1'b0; be2 = '0;
    tick();
    chk("rst_busy", 96'(busy), 96'd1);
    chk("rst_dout", dout, 96'h0);
    chk("nc_busy_after_rst", 96'(busy2), 96'd0);
    chk("nc_dout_after_rst", 96'(dout2), 96'd0);
    rst = 1'b0;
    rst2 = 1'b0;

    count_busy("clear_len");
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    for (int a = 0; a < 32; a++) cycle("read_after_clear", 1'b0, 5'd0, 32'h0, 4'h0, 5'(a), 5'(31 - a), 5'(a));

    // Reset mid-clear restarts the count.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    count_busy("clear_restart_len");
    cycle("mem3_zero", 1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd3, 5'd3);
    chk("mem3_const", dout[31:0], 96'h0);

    cycle("be_write", 1'b1, 5'd7, 32'h1122_3344, 4'b0101, 5'd0, 5'd0, 5'd0);
    cycle("be_read", 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd7, 5'd0);
    chk("be_read_const", dout[63:32], 96'h0022_0044);

    a_val = $urandom; b_val = $urandom;
    cycle("mp_wr_a", 1'b1, 5'd1, a_val, 4'hF, 5'd0, 5'd0, 5'd0);
    cycle("mp_wr_b", 1'b1, 5'd2, b_val, 4'hF, 5'd0, 5'd0, 5'd0);
    cycle("mp_read", 1'b0, 5'd0, 32'h0, 4'h0, 5'd1, 5'd1, 5'd2);
    chk("mp_read_const", dout, {b_val, a_val, a_val});

    cycle("rdw_init", 1'b1, 5'd5, 32'hAAAA_AAAA, 4'hF, 5'd0, 5'd0, 5'd0);
    cycle("rdw_full", 1'b1, 5'd5, 32'h5555_5555, 4'hF, 5'd5, 5'd0, 5'd0);
`ifdef MEM_ARRAY_MP_FWD_EN
    chk("rdw_full_const", dout[31:0], 96'h5555_5555);
`else
    chk("rdw_full_const", dout[31:0], 96'hAAAA_AAAA);
`endif
    cycle("rdw_reinit", 1'b1, 5'd5, 32'hAAAA_AAAA, 4'hF, 5'd0, 5'd0, 5'd0);
    cycle("rdw_part", 1'b1, 5'd5, 32'h5555_5555, 4'b0011, 5'd5, 5'd0, 5'd0);
`ifdef MEM_ARRAY_MP_FWD_EN
    chk("rdw_part_const", dout[31:0], 96'hAAAA_5555);
`else
    chk("rdw_part_const", dout[31:0], 96'hAAAA_AAAA);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      cycle("random", 1'($urandom), wa, $urandom, 4'($urandom),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom), 5'($urandom), 5'($urandom));
    end

    // No-clear instance with WORDS=24: out-of-range writes ignored, reads return 0.
    we2 = 1'b1; waddr2 = 5'd23; din2 = 32'hCAFE_F00D; be2 = 4'hF; tick();
    waddr2 = 5'd28; din2 = 32'hDEAD_BEEF; tick();
    we2 = 1'b1; waddr2 = 5'd4; din2 = 32'h0102_0304; be2 = 4'hF; raddr2 = 5'd23; tick();
    we2 = 1'b0;
    chk("nc_read_top", 96'(dout2), 96'hCAFE_F00D);
    raddr2 = 5'd28; tick();
    chk("nc_read_oor", 96'(dout2), 96'h0);
    raddr2 = 5'd4; tick();
    chk("nc_read_4", 96'(dout2), 96'h0102_0304);
    chk("nc_busy", 96'(busy2), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
